// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// riscv_pkg : shared widths, reset vector and the fetch FIFO entry type
// Rev 1.0
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : synchronous FIFO with registered storage, flush and occupancy
// Rev 1.0
// ============================================================================
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter type ENTRY_T = fetch_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  ENTRY_T                 push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output ENTRY_T                 head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ENTRY_T        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO may still accept a write when its head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : in-order instruction fetch with prefetch FIFO and redirect flush
// Rev 1.0
// ============================================================================
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   tag_count;
  logic [CW:0]     credit_used;
  logic            active;
  logic            fifo_full;
  logic            fifo_empty;
  logic            tag_full;
  logic            tag_empty;
  logic [XLEN-1:0] tag_pc;
  fetch_entry_t    head;
  fetch_entry_t    resp_entry;
  logic            req_fire;
  logic            resp_keep;
  logic            instr_pop;
  logic            unused_bits;

  // Requests are only issued when the FIFO is guaranteed room for every reply.
  assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = active & (credit_used < (CW+1)'(DEPTH)) & ~redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign resp_keep  = imem_resp_valid & (discard == '0) & ~redirect_valid;
  assign resp_entry = '{pc: tag_pc, instr: imem_resp_data};

  assign instr_valid = ~fifo_empty & ~redirect_valid;
  assign instr_pop   = instr_valid & instr_ready;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

  assign unused_bits = ^{redirect_pc[1:0], fifo_full, tag_full, tag_empty, tag_count};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      active      <= 1'b0;
    end else begin
      active      <= 1'b1;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        // Every reply still in flight after this edge belongs to the old path.
        discard  <= outstanding - CW'(imem_resp_valid);
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (imem_resp_valid && (discard != '0)) begin
          discard <= discard - CW'(1);
        end
      end
    end
  end

  fetch_fifo #(
    .ENTRY_T (logic [XLEN-1:0]),
    .DEPTH   (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (resp_keep),
    .flush     (redirect_valid),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count),
    .head      (tag_pc)
  );

  fetch_fifo #(
    .ENTRY_T (fetch_entry_t),
    .DEPTH   (DEPTH)
  ) u_instr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (resp_keep),
    .push_data (resp_entry),
    .pop       (instr_pop),
    .flush     (redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : scoreboard bench with an in-order random-latency memory model
// Rev 1.0
// ============================================================================
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  mreq_t       mq[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_next = RESET_PC;
  logic [31:0] exp_req_pc = RESET_PC;
  int          lat_min = 1;
  int          lat_max = 1;
  int          ready_pct = 100;
  int          fires = 0;
  int          delivered = 0;
  int          first_req_cyc = -1;
  int          first_val_cyc = -1;
  int          last_due = 0;
  int          mon_due;
  logic [31:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Memory model: in-order replies, per-request random latency, random ready.
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      imem_resp_valid = 1'b0;
      imem_req_ready  = 1'b0;
    end else begin
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mq[0].addr);
        mq.delete(0);
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
      end
      imem_req_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Monitor: request stream, delivered instructions and the credit invariant.
  always @(negedge clk) begin
    if (rst_n) begin
      if (redirect_valid) begin
        check("redirect_req_valid", 32'(imem_req_valid), 32'd0);
        check("redirect_instr_valid", 32'(instr_valid), 32'd0);
      end
      check("credit_invariant",
            32'((32'(dut.outstanding) + 32'(dut.fifo_count)) <= DEPTH), 32'd1);
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, exp_req_pc);
        exp_req_pc += 32'd4;
        fires++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
        mon_due = cyc + int'($urandom_range(lat_max, lat_min));
        if (mon_due < last_due) mon_due = last_due;
        last_due = mon_due;
        mq.push_back('{addr: imem_req_addr, due: mon_due});
      end
      if (instr_valid && first_val_cyc < 0) first_val_cyc = cyc;
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deliver: got instr_pc 0x%h, expected nothing queued", instr_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("instr_pc", instr_pc, mon_e);
          check("instr_word", instr, mem_word(mon_e));
        end
        delivered++;
      end
    end
  end

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(exp_next);
      exp_next += 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    refill();
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    int exp_disc;
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    exp_disc       = mq.size();
    exp_q.delete();
    exp_next   = tgt & 32'hFFFF_FFFC;
    exp_req_pc = exp_next;
    refill();
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    check("discard_after_redirect", 32'(dut.discard), 32'(exp_disc));
    refill();
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_req_ready  = 1'b0;
    mq.delete();
    exp_q.delete();
    last_due      = 0;
    exp_next      = RESET_PC;
    exp_req_pc    = RESET_PC;
    fires         = 0;
    delivered     = 0;
    first_req_cyc = -1;
    first_val_cyc = -1;
    #1;
    check("reset_req_valid", 32'(imem_req_valid), 32'd0);
    check("reset_instr_valid", 32'(instr_valid), 32'd0);
    check("reset_instr", instr, 32'd0);
    check("reset_instr_pc", instr_pc, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    refill();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    int found;

    #2;
    // Streaming fetch with single-cycle memory.
    instr_ready = 1'b1;
    do_reset();
    repeat (10) tick();
    n0 = delivered;
    repeat (16) tick();
    check("steady_throughput", 32'(delivered - n0), 32'd16);
    check("first_valid_latency", 32'(first_val_cyc - first_req_cyc), 32'd2);

    // Decoder stalled: credits must stop requests at DEPTH.
    instr_ready = 1'b0;
    do_reset();
    repeat (15) tick();
    check("stall_fires", 32'(fires), 32'(DEPTH));
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_instr_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    repeat (20) tick();

    // Redirect with two replies in flight at latency 3.
    lat_min = 3;
    lat_max = 3;
    do_reset();
    do_redirect(32'h20);
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      tick();
      if (mq.size() == 2 && !imem_resp_valid) found = 1;
    end
    check("redirect_l3_setup", 32'(found), 32'd1);
    do_redirect(32'h100);
    check("redirect_fifo_empty", 32'(instr_valid), 32'd0);
    repeat (15) tick();

    // Redirect coinciding with a reply, one more still in flight.
    lat_min = 2;
    lat_max = 2;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      tick();
      if (imem_resp_valid && mq.size() == 1) found = 1;
    end
    check("redirect_resp_setup", 32'(found), 32'd1);
    do_redirect(32'h200);
    repeat (10) tick();

    // Misaligned target and address wrap.
    lat_min = 1;
    lat_max = 1;
    do_redirect(32'h102);
    check("redirect_align", imem_req_addr, 32'h100);
    repeat (8) tick();
    do_redirect(32'hFFFF_FFFC);
    check("redirect_wrap_start", imem_req_addr, 32'hFFFF_FFFC);
    repeat (10) tick();

    // Asynchronous reset with a full FIFO.
    instr_ready = 1'b0;
    repeat (12) tick();
    check("full_before_reset", 32'(instr_valid), 32'd1);
    do_reset();
    instr_ready = 1'b1;
    repeat (10) tick();
    check("post_reset_fetching", 32'(fires > 0), 32'd1);

    // Randomized traffic.
    lat_min   = 1;
    lat_max   = 4;
    ready_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      instr_ready = ($urandom_range(99) < 75);
      if ($urandom_range(99) < 4) do_redirect($urandom);
      else tick();
    end

    instr_ready = 1'b1;
    ready_pct   = 100;
    n0 = delivered;
    repeat (40) tick();
    check("drain_progress", 32'(delivered > n0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
